// File: rtl/pipe_stage_buffer.sv
// Two-entry skid buffer for pipeline stage boundaries (e.g. IF/ID), with registered in_ready.
// Optional stall cycle counter enabled by defining PIPE_STALL_CNT_EN.
module pipe_stage_buffer #(
    parameter int                DATA_W     = 64,
    parameter logic [DATA_W-1:0] FLUSH_DATA = {DATA_W{1'b0}}
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic [1:0]        occupancy
`ifdef PIPE_STALL_CNT_EN
    ,
    output logic [15:0]       stall_count
`endif
);

    // Handshake: a beat moves on a rising edge when valid && ready are both high on that side;
    // valid never depends on ready, and in_ready is a register so it never follows out_ready.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HALF  = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] main_q;
    logic [DATA_W-1:0] skid_q;
    logic              accept;
    logic              release_beat;

    assign accept       = in_valid && in_ready;
    assign release_beat = out_valid && out_ready;
    assign out_data     = main_q;
    // The state encoding is the entry count, so occupancy doubles as the FSM debug view.
    assign occupancy    = state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= EMPTY;
            main_q    <= FLUSH_DATA;
            skid_q    <= FLUSH_DATA;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else if (flush) begin
            state     <= EMPTY;
            main_q    <= FLUSH_DATA;
            skid_q    <= FLUSH_DATA;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        main_q    <= in_data;
                        out_valid <= 1'b1;
                        state     <= HALF;
                    end
                end
                HALF: begin
                    if (accept && release_beat) begin
                        main_q <= in_data;
                    end else if (accept) begin
                        // Downstream stalled: park the new beat so main stays stable.
                        skid_q   <= in_data;
                        in_ready <= 1'b0;
                        state    <= FULL;
                    end else if (release_beat) begin
                        out_valid <= 1'b0;
                        state     <= EMPTY;
                    end
                end
                FULL: begin
                    if (release_beat) begin
                        main_q   <= skid_q;
                        in_ready <= 1'b1;
                        state    <= HALF;
                    end
                end
                default: begin
                    state     <= EMPTY;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

`ifdef PIPE_STALL_CNT_EN
    // Saturating count of stalled cycles; flush deliberately leaves it alone.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_count <= 16'h0000;
        end else if (out_valid && !out_ready && (stall_count != 16'hFFFF)) begin
            stall_count <= stall_count + 16'h0001;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_stage_buffer.sv
// Directed bench for pipe_stage_buffer: reset, streaming, backpressure, flush, async reset
// and, when PIPE_STALL_CNT_EN is defined, the stall counter.
module tb_pipe_stage_buffer;

    localparam int DATA_W = 64;

    logic              clk = 1'b0;
    logic              reset;
    logic              flush;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_ready;
    logic [1:0]        occupancy;
`ifdef PIPE_STALL_CNT_EN
    logic [15:0]       stall_count;
`endif

    int total = 0;
    int bad   = 0;

    pipe_stage_buffer #(.DATA_W(DATA_W)) dut (
        .clk(clk),
        .reset(reset),
        .flush(flush),
        .in_valid(in_valid),
        .in_data(in_data),
        .in_ready(in_ready),
        .out_valid(out_valid),
        .out_data(out_data),
        .out_ready(out_ready),
        .occupancy(occupancy)
`ifdef PIPE_STALL_CNT_EN
        ,
        .stall_count(stall_count)
`endif
    );

    always #5 clk = ~clk;

    // Advance one rising edge and settle 1 ns past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        #12;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
        total++; if (occupancy !== 2'd0) begin bad++; $display("FAIL reset_occupancy got=%0d exp=0", occupancy); end
        total++; if (out_data !== 64'h0) begin bad++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_streaming();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            in_data = DATA_W'(i);
            tick();
            total++; if (out_data !== DATA_W'(i)) begin bad++; $display("FAIL stream_data%0d got=%h exp=%h", i, out_data, DATA_W'(i)); end
            total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL stream_valid%0d got=%0b exp=1", i, out_valid); end
            total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL stream_in_ready%0d got=%0b exp=1", i, in_ready); end
            total++; if (occupancy !== 2'd1) begin bad++; $display("FAIL stream_occ%0d got=%0d exp=1", i, occupancy); end
        end
        in_valid = 1'b0;
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL stream_drain_valid got=%0b exp=0", out_valid); end
        total++; if (occupancy !== 2'd0) begin bad++; $display("FAIL stream_drain_occ got=%0d exp=0", occupancy); end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        in_valid  = 1'b1; in_data = 64'hA;
        tick();
        total++; if (out_data !== 64'hA) begin bad++; $display("FAIL bp_main got=%h exp=a", out_data); end
        in_data = 64'hB;
        tick();
        total++; if (occupancy !== 2'd2) begin bad++; $display("FAIL bp_full_occ got=%0d exp=2", occupancy); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_full_in_ready got=%0b exp=0", in_ready); end
        total++; if (out_data !== 64'hA) begin bad++; $display("FAIL bp_hold1 got=%h exp=a", out_data); end
        in_data = 64'hC;
        tick();
        total++; if (out_data !== 64'hA) begin bad++; $display("FAIL bp_hold2 got=%h exp=a", out_data); end
        total++; if (occupancy !== 2'd2) begin bad++; $display("FAIL bp_hold_occ got=%0d exp=2", occupancy); end
        out_ready = 1'b1;
        tick();
        total++; if (out_data !== 64'hB) begin bad++; $display("FAIL bp_skid_out got=%h exp=b", out_data); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_reopen got=%0b exp=1", in_ready); end
        total++; if (occupancy !== 2'd1) begin bad++; $display("FAIL bp_half_occ got=%0d exp=1", occupancy); end
        tick();
        total++; if (out_data !== 64'hC) begin bad++; $display("FAIL bp_c_out got=%h exp=c", out_data); end
        in_valid = 1'b0;
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_drain got=%0b exp=0", out_valid); end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        in_valid  = 1'b1; in_data = 64'h5;
        tick();
        in_data = 64'h6;
        tick();
        total++; if (occupancy !== 2'd2) begin bad++; $display("FAIL flush_pre_occ got=%0d exp=2", occupancy); end
        in_data = 64'h7; flush = 1'b1; out_ready = 1'b1;
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_valid got=%0b exp=0", out_valid); end
        total++; if (occupancy !== 2'd0) begin bad++; $display("FAIL flush_occ got=%0d exp=0", occupancy); end
        total++; if (out_data !== 64'h0) begin bad++; $display("FAIL flush_data got=%h exp=0", out_data); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL flush_in_ready got=%0b exp=1", in_ready); end
        flush = 1'b0; in_valid = 1'b0;
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_no_capture got=%0b exp=0", out_valid); end
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        in_valid  = 1'b1; in_data = 64'h33;
        tick();
        in_valid = 1'b0;
        total++; if (occupancy !== 2'd1) begin bad++; $display("FAIL ar_pre_occ got=%0d exp=1", occupancy); end
        #3;
        reset = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL ar_valid got=%0b exp=0", out_valid); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL ar_in_ready got=%0b exp=1", in_ready); end
        total++; if (occupancy !== 2'd0) begin bad++; $display("FAIL ar_occ got=%0d exp=0", occupancy); end
        total++; if (out_data !== 64'h0) begin bad++; $display("FAIL ar_data got=%h exp=0", out_data); end
        #2;
        reset = 1'b1;
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL ar_after got=%0b exp=0", out_valid); end
    endtask

`ifdef PIPE_STALL_CNT_EN
    task automatic test_stall_count();
        #3; reset = 1'b0; #1;
        total++; if (stall_count !== 16'h0) begin bad++; $display("FAIL sc_reset got=%h exp=0", stall_count); end
        #2; reset = 1'b1;
        out_ready = 1'b0;
        in_valid  = 1'b1; in_data = 64'h9;
        tick();
        in_valid = 1'b0;
        repeat (5) tick();
        total++; if (stall_count !== 16'd5) begin bad++; $display("FAIL sc_five got=%0d exp=5", stall_count); end
        flush = 1'b1; out_ready = 1'b1;
        tick();
        flush = 1'b0;
        tick();
        total++; if (stall_count !== 16'd5) begin bad++; $display("FAIL sc_flush_keep got=%0d exp=5", stall_count); end
        out_ready = 1'b0;
        in_valid  = 1'b1; in_data = 64'h1;
        tick();
        in_valid = 1'b0;
        repeat (70000) tick();
        total++; if (stall_count !== 16'hFFFF) begin bad++; $display("FAIL sc_saturate got=%h exp=ffff", stall_count); end
    endtask
`endif

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_flush();
        test_async_reset();
`ifdef PIPE_STALL_CNT_EN
        test_stall_count();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipe_stage_buffer.md
PIPE_STAGE_BUFFER -- requirements
Module: pipe_stage_buffer

Interface
REQ-001 SHALL have parameter DATA_W, default 64, meaning payload width (instruction[31:0] + PC+4[63:32] in the IF/ID use).
REQ-002 SHALL have parameter FLUSH_DATA, default {DATA_W{1'b0}}, meaning the payload value loaded on reset and on flush.
REQ-003 SHALL have port clk  input  1  clock; all state changes occur on the rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port flush  input  1  synchronous squash of all buffered entries.
REQ-006 SHALL have port in_valid  input  1  upstream has a payload.
REQ-007 SHALL have port in_data  input  DATA_W  upstream payload.
REQ-008 SHALL have port in_ready  output  1  stage can accept; registered, not combinationally dependent on out_ready.
REQ-009 SHALL have port out_valid  output  1  out_data holds a valid payload.
REQ-010 SHALL have port out_data  output  DATA_W  downstream payload, driven directly from a register.
REQ-011 SHALL have port out_ready  input  1  downstream accepts (low = stall).
REQ-012 SHALL have port occupancy  output  2  number of held entries, 0..2.

Function
REQ-013 SHALL be a 2-entry skid buffer: a main register driving out_data/out_valid, plus a skid register.
REQ-014 SHALL use states EMPTY (0 entries), HALF (main only), FULL (main + skid); occupancy SHALL equal 0/1/2 respectively.
REQ-015 SHALL accept a transfer when in_valid && in_ready, and release one when out_valid && out_ready.
REQ-016 SHALL, in EMPTY with accept, load main and move to HALF; out_valid rises the next cycle (1-cycle latency).
REQ-017 SHALL, in HALF with accept and release together, reload main and stay in HALF (sustained 1 transfer/cycle).
REQ-018 SHALL, in HALF with accept and no release, load skid and move to FULL; in_ready SHALL be 0 from the next cycle.
REQ-019 SHALL, in HALF with release and no accept, clear out_valid and move to EMPTY.
REQ-020 SHALL, in FULL with release, move skid into main and go to HALF; in_ready SHALL be 1 from the next cycle.
REQ-021 SHALL hold main data stable while out_valid && !out_ready; no payload is ever lost, duplicated or reordered.
REQ-022 SHALL, on flush, go to EMPTY next cycle, load FLUSH_DATA into both registers, and set in_ready=1; flush overrides a simultaneous accept or release.
REQ-023 SHALL ignore in_data whenever in_valid=0 or in_ready=0.

Reset
REQ-024 SHALL, on reset low and regardless of clk: state EMPTY, out_valid=0, out_data=FLUSH_DATA, skid=FLUSH_DATA, in_ready=1, occupancy=0.
REQ-025 SHALL, when reset is released, resume at the first rising edge; reset asserted mid-transfer discards all entries.

Configuration
REQ-026 SHALL, with macro PIPE_STALL_CNT_EN defined, add output stall_count (16 bits) counting cycles with out_valid && !out_ready, saturating at 16'hFFFF, cleared only by reset (not by flush).
REQ-027 SHALL, without PIPE_STALL_CNT_EN, omit the stall_count port and its logic entirely, with all other behaviour identical.

Verification
REQ-028 SHALL verify streaming: out_ready=1, in_data=1,2,3,4 on consecutive cycles -> out_data 1,2,3,4 one cycle later each, in_ready constant 1.
REQ-029 SHALL verify backpressure: with 0xA in main, hold out_ready=0 and offer 0xB, 0xC -> 0xB is skidded, in_ready=0, occupancy=2; then release -> out_data 0xA, then 0xB, then 0xC is accepted.
REQ-030 SHALL verify flush with FULL (0x5, 0x6) and in_valid=1 offering 0x7 -> next cycle out_valid=0, occupancy=0, out_data=FLUSH_DATA, 0x7 is not captured.
REQ-031 SHALL verify async reset: assert reset between clock edges while in HALF -> out_valid=0 and in_ready=1 immediately, without waiting for clk.
REQ-032 SHALL verify the counter with PIPE_STALL_CNT_EN: 5 stalled cycles -> stall_count=5, and the count is retained across flush; force 70000 stalled cycles -> stall_count=16'hFFFF.
